nn_output_classifier: RTL and testbench
=======================================

NN_OUTPUT_CLASSIFIER -- requirements
Module: nn_output_classifier

Interface
REQ-001 SHALL have parameter NUM_CLASSES, default 10, number of output-layer scores, legal range 2..16.
REQ-002 SHALL have parameter SCORE_W, default 8, width of each signed two's-complement score.
REQ-003 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, level request; a run is triggered by its rising edge, and start may stay high for several cycles.
REQ-006 SHALL have port scores, input, NUM_CLASSES*SCORE_W, class i on bits [i*SCORE_W+SCORE_W-1 : i*SCORE_W].
REQ-007 SHALL have port result, output, 4, index of the winning class.
REQ-008 SHALL have port max_score, output, SCORE_W, signed winning score.
REQ-009 SHALL have port margin, output, SCORE_W+1, unsigned (winner - runner-up).
REQ-010 SHALL have port ready, output, 1, high while outputs are valid and block is idle.

Function
REQ-011 SHALL implement states IDLE, SCAN, DONE.
REQ-012 SHALL register start every cycle (start_d); rising edge = start & ~start_d.
REQ-013 On a rising edge in IDLE or DONE, SHALL, at that clock edge, capture all scores into an internal register, clear ready, set index 0 and enter SCAN.
REQ-014 SHALL ignore start edges and scores changes while in SCAN, so the captured copy is used for the whole run.
REQ-015 In SCAN, SHALL examine exactly one captured score per cycle, in index order 0..NUM_CLASSES-1.
REQ-016 SHALL keep best and second-best values using a signed compare.
REQ-017 SHALL break ties toward the lower index: a later score replaces best only if strictly greater.
REQ-018 SHALL make an equal later score become second-best, so that margin = 0.
REQ-019 After the last index, SHALL enter DONE and drive result, max_score and margin from the completed run with ready=1.
REQ-020 Latency: ready SHALL rise at clock edge k+NUM_CLASSES+1, where k is the edge that accepted start.
REQ-021 In DONE, SHALL hold ready and all outputs stable until the next accepted start edge.
REQ-022 result, max_score and margin SHALL change only on entry to DONE, never mid-scan.
REQ-023 SHALL compute margin as the exact difference at SCORE_W+1 bits with no overflow; maximum value 2^SCORE_W - 1.
REQ-024 SHALL drive the upper result bits with zero when NUM_CLASSES < 16.
REQ-025 A start edge in the same cycle that DONE is entered SHALL NOT be accepted.
REQ-026 A start edge in the same cycle that DONE is entered SHALL instead be accepted on a later cycle if start is then low and rises again.

Reset
REQ-027 On rst=1 at a clock edge, SHALL go to IDLE.
REQ-028 On rst=1 at a clock edge, SHALL set ready=0, result=0, max_score=0, margin=0 and start_d=0.
REQ-029 On rst=1 at a clock edge, SHALL clear the captured scores.
REQ-030 rst SHALL take priority over start in the same cycle.
REQ-031 rst during SCAN SHALL abort the run with no partial output.
REQ-032 After reset, start held high SHALL trigger a run only once start_d has been loaded: a start high through reset release produces an edge on the first cycle after release.

Verification
REQ-033 Scores {3,-5,7,0,1,2,-1,6,4,5}, one start pulse -> ready rises at edge k+11; result=2, max_score=7, margin=1.
REQ-034 All ten scores = 0x80 (-128) -> result=0, max_score=-128, margin=0; equal scores = 9 and 4, others lower -> result=4, margin=0.
REQ-035 Score[9]=127, others -128 -> result=9, max_score=127, margin=255 (full-range margin, no wrap).
REQ-036 Start held high for 3 cycles -> exactly one run.
REQ-037 Scores changed and a second start edge issued mid-SCAN -> the edge is ignored and outputs reflect the original captured scores.
REQ-038 rst asserted 4 cycles into SCAN -> ready=0, all outputs 0, state IDLE; a subsequent start gives a correct fresh result after 11 cycles.

Source files
------------

// File: rtl/nn_output_classifier.sv
// Picks the arg-max of NUM_CLASSES signed scores, one score per cycle, and reports
// the winning index, its score and the margin over the runner-up.
module nn_output_classifier #(
    parameter int NUM_CLASSES = 10,
    parameter int SCORE_W     = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [NUM_CLASSES*SCORE_W-1:0] scores,
    output logic [3:0]                     result,
    output logic signed [SCORE_W-1:0]      max_score,
    output logic [SCORE_W:0]               margin,
    output logic                           ready,
    output logic [1:0]                     o_dbg_state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [4:0]                LAST_CNT  = 5'(NUM_CLASSES);
    localparam logic signed [SCORE_W-1:0] MIN_SCORE = {1'b1, {(SCORE_W-1){1'b0}}};

    logic [1:0]                r_state;
    logic                      r_start_d;
    logic signed [SCORE_W-1:0] r_cap [NUM_CLASSES];
    logic [4:0]                r_cnt;
    logic signed [SCORE_W-1:0] r_best;
    logic signed [SCORE_W-1:0] r_second;
    logic [3:0]                r_bidx;
    logic [3:0]                r_result;
    logic signed [SCORE_W-1:0] r_max;
    logic [SCORE_W:0]          r_margin;
    logic                      r_ready;

    logic                      w_start_edge;
    logic signed [SCORE_W-1:0] w_cur;
    logic                      w_gt_best;
    logic                      w_gt_second;
    logic [SCORE_W:0]          w_margin;

    assign w_start_edge = start & ~r_start_d;
    assign w_cur        = r_cap[0];
    assign w_gt_best    = w_cur > r_best;
    assign w_gt_second  = w_cur > r_second;
    // Sign-extend both operands so the full-range difference cannot wrap.
    assign w_margin     = {r_best[SCORE_W-1], r_best} - {r_second[SCORE_W-1], r_second};

    // Captured scores shift toward slot 0, so the scan always examines r_cap[0].
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_start_d <= 1'b0;
            for (int i = 0; i < NUM_CLASSES; i++) r_cap[i] <= '0;
            r_cnt     <= '0;
            r_best    <= MIN_SCORE;
            r_second  <= MIN_SCORE;
            r_bidx    <= '0;
            r_result  <= '0;
            r_max     <= '0;
            r_margin  <= '0;
            r_ready   <= 1'b0;
        end else begin
            r_start_d <= start;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start_edge) begin
                        for (int i = 0; i < NUM_CLASSES; i++)
                            r_cap[i] <= scores[i*SCORE_W +: SCORE_W];
                        r_cnt    <= '0;
                        r_best   <= MIN_SCORE;
                        r_second <= MIN_SCORE;
                        r_bidx   <= '0;
                        r_ready  <= 1'b0;
                        r_state  <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (r_cnt == LAST_CNT) begin
                        r_result <= r_bidx;
                        r_max    <= r_best;
                        r_margin <= w_margin;
                        r_ready  <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        for (int i = 0; i < NUM_CLASSES-1; i++) r_cap[i] <= r_cap[i+1];
                        r_cap[NUM_CLASSES-1] <= '0;
                        r_cnt <= r_cnt + 5'd1;
                        // Strict compare keeps the lower index on ties; an equal score drops to second.
                        if (w_gt_best) begin
                            r_second <= r_best;
                            r_best   <= w_cur;
                            r_bidx   <= r_cnt[3:0];
                        end else if (w_gt_second) begin
                            r_second <= w_cur;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign result      = r_result;
    assign max_score   = r_max;
    assign margin      = r_margin;
    assign ready       = r_ready;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_nn_output_classifier.sv
// Scoreboard bench for nn_output_classifier: expected {result, max, margin} pushed at
// start, popped and compared when ready rises.
module tb_nn_output_classifier;
  localparam int NC = 10;
  localparam int W  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [NC*W-1:0] scores = '0;
  logic [3:0]    result;
  logic [W-1:0]  max_score;
  logic [W:0]    margin;
  logic          ready;
  logic [1:0]    dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  int cur_s [NC];
  logic [20:0] exp_q[$];

  nn_output_classifier #(.NUM_CLASSES(NC), .SCORE_W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .scores(scores),
    .result(result), .max_score(max_score), .margin(margin),
    .ready(ready), .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: lowest index wins ties, an equal later score becomes runner-up.
  function automatic logic [20:0] model();
    int best, second, bi;
    best = cur_s[0]; second = -100000; bi = 0;
    for (int i = 1; i < NC; i++) begin
      if (cur_s[i] > best) begin
        second = best; best = cur_s[i]; bi = i;
      end else if (cur_s[i] > second) begin
        second = cur_s[i];
      end
    end
    return {4'(bi), 8'(best), 9'(best - second)};
  endfunction

  task automatic drive_scores();
    for (int i = 0; i < NC; i++) scores[i*W +: W] = 8'(cur_s[i]);
  endtask

  task automatic rand_scores();
    for (int i = 0; i < NC; i++) cur_s[i] = int'($urandom_range(0, 255)) - 128;
  endtask

  // mode 0: plain; 1: scores changed and start re-pulsed mid-scan; 2: start rises as DONE is entered.
  task automatic run(input string tag, input int hold, input int mode);
    int edges;
    bit got;
    logic [20:0] e;
    drive_scores();
    exp_q.push_back(model());
    start = 1'b1;
    @(posedge clk);
    edges = 0; got = 0;
    while (!got && edges < 40) begin
      @(negedge clk);
      if (ready) got = 1;
      else begin
        if (edges + 1 >= hold) start = 1'b0;
        if (mode == 1 && edges == 2) begin
          for (int i = 0; i < NC; i++) scores[i*W +: W] = 8'($urandom_range(0, 255));
          start = 1'b1;
        end
        if (mode == 2 && edges == NC) start = 1'b1;
        @(posedge clk);
        edges++;
      end
    end
    check({tag, "_latency"}, edges, NC + 1);
    e = exp_q.pop_front();
    check({tag, "_result"}, result, e[20:17]);
    check({tag, "_max"}, max_score, e[16:9]);
    check({tag, "_margin"}, margin, e[8:0]);
    check({tag, "_state"}, dbg_state, 2);
    repeat (3) @(negedge clk);
    check({tag, "_hold_ready"}, ready, 1);
    check({tag, "_hold_result"}, result, e[20:17]);
    check({tag, "_hold_margin"}, margin, e[8:0]);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_ready"}, ready, 0);
    check({tag, "_result"}, result, 0);
    check({tag, "_max"}, max_score, 0);
    check({tag, "_margin"}, margin, 0);
    check({tag, "_state"}, dbg_state, 0);
  endtask

  initial begin
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_cleared("reset");

    cur_s = '{3, -5, 7, 0, 1, 2, -1, 6, 4, 5};
    run("basic", 1, 0);

    for (int i = 0; i < NC; i++) cur_s[i] = -128;
    run("all_min", 1, 0);

    for (int i = 0; i < NC; i++) cur_s[i] = 1;
    cur_s[4] = 50; cur_s[9] = 50;
    run("tie", 1, 0);

    for (int i = 0; i < NC; i++) cur_s[i] = -128;
    cur_s[9] = 127;
    run("full_margin", 1, 0);

    rand_scores();
    run("hold3", 3, 0);

    rand_scores();
    run("disturb", 1, 1);

    // Abort a run four cycles into the scan.
    rand_scores();
    drive_scores();
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_cleared("abort");
    repeat (2) @(negedge clk);
    check("abort_no_output", ready, 0);

    rand_scores();
    run("after_abort", 1, 0);

    // Start held high across reset release starts a run on the first cycle after release.
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rand_scores();
    run("thru_reset", 1, 0);

    rand_scores();
    run("edge_at_done", 1, 2);
    check("edge_at_done_ignored", dbg_state, 2);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);

    for (int r = 0; r < 4; r++) begin
      rand_scores();
      run("random", 1 + (r % 2), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
